// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared state codes, bus levels and flag
// constants for the data-side memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'b00,
    BR_BUS  = 2'b01,
    BR_DONE = 2'b10
  } br_state_e;

  localparam logic        BUS_REQ    = 1'b1;
  localparam logic        BUS_IDLE   = 1'b0;
  localparam logic        VALID      = 1'b1;
  localparam logic        SET_FLAG   = 1'b1;
  localparam logic        CLEAR_FLAG = 1'b0;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO       = 32'h0000_0000;

  function automatic logic word_aligned(
    input logic [1:0] lo
  );
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bridge_ll_link.sv
// ll_link_reg: LL link flag and linked word address.
// Flush beats commit, commit beats store snoop.
module ll_link_reg
  import dmem_bridge_pkg::*;
#(
  parameter int SNOOP_CLR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        commit,
  input  logic        commit_val,
  input  logic        snoop,
  input  logic [29:0] addr,
  output logic        rLLbit
);

  logic [29:0] link_addr;
  logic        snoop_hit;

  // a completed store to the linked word breaks the link
  assign snoop_hit = (SNOOP_CLR != 0) && snoop &&
                     (addr == link_addr);

  // link flag and address update, highest priority first
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rLLbit    <= CLEAR_FLAG;
      link_addr <= '0;
    end else if (flush) begin
      rLLbit <= CLEAR_FLAG;
    end else if (commit) begin
      rLLbit <= commit_val;
      if (commit_val == SET_FLAG) begin
        link_addr <= addr;
      end
    end else if (snoop_hit) begin
      rLLbit <= CLEAR_FLAG;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data bridge running one req/ack
// bus cycle per access, stalling the pipe until it ends.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int SNOOP_CLR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic        wbit,
  input  logic        wLLbit,
  input  logic        flush,
  output logic [31:0] rdData,
  output logic        rLLbit,
  output logic        stallReq,
  output logic        memErr,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  input  logic        busAck,
  input  logic [31:0] busRdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  br_state_e   state;
  br_state_e   state_nx;
  logic [TW-1:0] tcnt;
  logic        drop;
  logic        err_flag;
  logic        lat_we;
  logic        lat_wbit;
  logic        lat_wll;
  logic        issue;
  logic        misal;
  logic        finish;
  logic        in_done;
  logic        commit;
  logic        snoop;

  // next state plus the one-cycle decode strobes
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    misal    = 1'b0;
    finish   = 1'b0;
    unique case (state)
      BR_IDLE: begin
        if (memCe == VALID && !flush) begin
          if (word_aligned(memAddr[1:0])) begin
            issue    = 1'b1;
            state_nx = BR_BUS;
          end else begin
            misal    = 1'b1;
            state_nx = BR_DONE;
          end
        end
      end
      BR_BUS: begin
        if (busAck || tcnt == LAST) begin
          finish   = 1'b1;
          state_nx = (drop || flush) ? BR_IDLE
                                     : BR_DONE;
        end
      end
      BR_DONE: begin
        state_nx = BR_IDLE;
      end
      default: begin
        state_nx = BR_IDLE;
      end
    endcase
  end

  // state register; reset abandons any open bus cycle
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= BR_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // bus regs, latched request, timeout count and load data
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      busReq   <= BUS_IDLE;
      busWe    <= 1'b0;
      busAddr  <= ZERO;
      busWdata <= ZERO;
      rdData   <= ZERO;
      lat_we   <= 1'b0;
      lat_wbit <= 1'b0;
      lat_wll  <= 1'b0;
      err_flag <= 1'b0;
      tcnt     <= '0;
      drop     <= 1'b0;
    end else begin
      if (issue) begin
        busReq   <= BUS_REQ;
        busWe    <= memWr;
        busAddr  <= {memAddr[31:2], 2'b00};
        busWdata <= wtData;
        lat_we   <= memWr;
        lat_wbit <= wbit;
        lat_wll  <= wLLbit;
        err_flag <= 1'b0;
        tcnt     <= '0;
        drop     <= 1'b0;
      end
      if (misal) begin
        lat_we   <= memWr;
        lat_wbit <= wbit;
        lat_wll  <= wLLbit;
        err_flag <= 1'b1;
        if (!memWr) begin
          rdData <= ZERO;
        end
      end
      if (state == BR_BUS) begin
        if (flush) begin
          drop <= 1'b1;
        end
        if (!finish) begin
          tcnt <= tcnt + 1'b1;
        end else begin
          busReq <= BUS_IDLE;
          busWe  <= 1'b0;
          drop   <= 1'b0;
          if (!(drop || flush)) begin
            err_flag <= !busAck;
            if (!lat_we) begin
              rdData <= busAck ? busRdata : ZERO;
            end
          end
        end
      end
    end
  end

  assign in_done  = (state == BR_DONE);
  assign stallReq = ((state == BR_IDLE) && memCe &&
                     !flush) || (state == BR_BUS);
  assign memErr   = in_done && err_flag;
  assign commit   = in_done && lat_wbit && !err_flag;
  assign snoop    = in_done && lat_we && !err_flag;

  ll_link_reg #(
    .SNOOP_CLR(SNOOP_CLR)
  ) u_link (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .commit    (commit),
    .commit_val(lat_wll),
    .snoop     (snoop),
    .addr      (busAddr[31:2]),
    .rLLbit    (rLLbit)
  );

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed ops, expected results queued
// by stimulus and checked by completion/bus monitors.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memCe = 1'b0;
  logic        memWr = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] wtData = '0;
  logic        wbit = 1'b0;
  logic        wLLbit = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rdData;
  logic        rLLbit;
  logic        stallReq;
  logic        memErr;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic        busAck = 1'b0;
  logic [31:0] busRdata = '0;

  typedef struct {
    int          stall;
    logic [31:0] rd;
    logic        err;
    logic        ll;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    resp_en = 1'b0;
  int    ack_dly = 0;
  logic [31:0] ack_data = '0;

  dmem_bridge #(
    .TIMEOUT  (16),
    .SNOOP_CLR(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .memCe   (memCe),
    .memWr   (memWr),
    .memAddr (memAddr),
    .wtData  (wtData),
    .wbit    (wbit),
    .wLLbit  (wLLbit),
    .flush   (flush),
    .rdData  (rdData),
    .rLLbit  (rLLbit),
    .stallReq(stallReq),
    .memErr  (memErr),
    .busReq  (busReq),
    .busWe   (busWe),
    .busAddr (busAddr),
    .busWdata(busWdata),
    .busAck  (busAck),
    .busRdata(busRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // bus slave: ack ack_dly cycles into the request
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        busAck = 1'b0;
        if (busReq) begin
          if (rcnt == ack_dly) begin
            busAck   = 1'b1;
            busRdata = ack_data;
            rcnt     = 0;
          end else begin
            rcnt++;
          end
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  // completion monitor: stall falls -> one op ended
  initial begin
    int    sc;
    bit    prev;
    done_t e;
    sc   = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stallReq === 1'b1) begin
        sc++;
        prev = 1'b1;
      end else if (prev) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got op, expected none");
        end else begin
          e = done_q.pop_front();
          chk("stall_cycles", sc, e.stall);
          chk("rdData", rdData, e.rd);
          chk("memErr", {31'b0, memErr}, {31'b0, e.err});
          @(negedge clk);
          chk("rLLbit_after", {31'b0, rLLbit}, {31'b0, e.ll});
          chk("memErr_pulse", {31'b0, memErr}, 32'd0);
        end
        prev = (stallReq === 1'b1);
        sc   = prev ? 1 : 0;
      end else begin
        prev = 1'b0;
      end
    end
  end

  // bus monitor: check request fields at each ack
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (busReq === 1'b1 && busAck === 1'b1) begin
        if (bus_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bus: got addr %h, expected none",
                   busAddr);
        end else begin
          b = bus_q.pop_front();
          chk("busAddr", busAddr, b.addr);
          chk("busWe", {31'b0, busWe}, {31'b0, b.we});
          chk("busWdata", busWdata, b.wdata);
        end
      end
    end
  end

  task automatic wait_free(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stallReq === 1'b1 && n < limit);
    if (stallReq === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL op_timeout: got stall after %0d, expected release", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input logic [31:0] a, input logic we,
    input logic [31:0] wd, input logic wb,
    input logic wl, input int dly,
    input logic [31:0] brd, input int e_stall,
    input logic [31:0] e_rd, input logic e_err,
    input logic e_ll
  );
    done_t d;
    bus_t  b;
    d = '{stall: e_stall, rd: e_rd, err: e_err, ll: e_ll};
    done_q.push_back(d);
    if (dly >= 0 && a[1:0] == 2'b00) begin
      b = '{addr: {a[31:2], 2'b00}, we: we, wdata: wd};
      bus_q.push_back(b);
    end
    resp_en  = (dly >= 0);
    ack_dly  = dly;
    ack_data = brd;
    memAddr  = a;
    memWr    = we;
    wtData   = wd;
    wbit     = wb;
    wLLbit   = wl;
    memCe    = 1'b1;
    wait_free(64);
    memCe = 1'b0;
    wbit  = 1'b0;
  endtask

  initial begin
    done_t d;
    bus_t  b;
    #200000;
    $display("FAIL watchdog: got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t d;
    bus_t  b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdData", rdData, 32'h0);
    chk("rst_rLLbit", {31'b0, rLLbit}, 32'h0);
    chk("rst_stallReq", {31'b0, stallReq}, 32'h0);
    chk("rst_memErr", {31'b0, memErr}, 32'h0);
    chk("rst_busReq", {31'b0, busReq}, 32'h0);
    chk("rst_busWe", {31'b0, busWe}, 32'h0);
    chk("rst_busAddr", busAddr, 32'h0);
    chk("rst_busWdata", busWdata, 32'h0);
    @(posedge clk);
    #1;

    run_op(32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF,
           2, 32'hDEADBEEF, 0, 0);
    run_op(32'h204, 1, 32'h12345678, 0, 0, 5, 0,
           7, 32'hDEADBEEF, 0, 0);
    run_op(32'h300, 0, 0, 1, 1, 1, 32'h0000AAAA,
           3, 32'h0000AAAA, 0, 1);
    run_op(32'h300, 1, 32'h55, 1, 0, 0, 0,
           2, 32'h0000AAAA, 0, 0);
    run_op(32'h300, 0, 0, 1, 1, 0, 32'h11,
           2, 32'h11, 0, 1);
    run_op(32'h300, 1, 32'h77, 0, 0, 0, 0,
           2, 32'h11, 0, 0);
    run_op(32'h304, 0, 0, 1, 1, 0, 32'h22,
           2, 32'h22, 0, 1);
    run_op(32'h308, 1, 32'h88, 0, 0, 0, 0,
           2, 32'h22, 0, 1);
    run_op(32'h102, 0, 0, 0, 0, 0, 32'hFFFF,
           1, 32'h0, 1, 1);
    run_op(32'h104, 0, 0, 0, 0, 0, 32'h33,
           2, 32'h33, 0, 1);
    run_op(32'h500, 0, 0, 0, 0, -1, 0,
           17, 32'h0, 1, 1);

    // flush one cycle into a load's bus cycle
    d = '{stall: 5, rd: 32'h0, err: 1'b0, ll: 1'b0};
    done_q.push_back(d);
    b = '{addr: 32'h600, we: 1'b0, wdata: 32'h0};
    bus_q.push_back(b);
    resp_en  = 1'b1;
    ack_dly  = 3;
    ack_data = 32'h99;
    memAddr  = 32'h600;
    memWr    = 1'b0;
    wtData   = 32'h0;
    memCe    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    memCe = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_free(40);

    run_op(32'h700, 0, 0, 1, 1, 0, 32'h44,
           2, 32'h44, 0, 1);

    // reset in the middle of a bus cycle
    d = '{stall: 4, rd: 32'h0, err: 1'b0, ll: 1'b0};
    done_q.push_back(d);
    resp_en = 1'b0;
    memAddr = 32'h400;
    memWr   = 1'b0;
    memCe   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    memCe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_busReq", {31'b0, busReq}, 32'h0);
    chk("rst_bus_stall", {31'b0, stallReq}, 32'h0);
    @(posedge clk);
    #1;
    busAck   = 1'b1;
    busRdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    busAck = 1'b0;
    @(negedge clk);
    chk("late_ack_rdData", rdData, 32'h0);
    chk("late_ack_stall", {31'b0, stallReq}, 32'h0);
    chk("late_ack_busReq", {31'b0, busReq}, 32'h0);

    // flushed request in IDLE never stalls or issues
    @(posedge clk);
    #1;
    memAddr = 32'h800;
    memCe   = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", {31'b0, stallReq}, 32'h0);
    @(posedge clk);
    #1;
    memCe = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busReq", {31'b0, busReq}, 32'h0);

    repeat (4) @(negedge clk);
    chk("done_q_empty", done_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
